mem_burst_master: RTL and testbench

Initiator-side engine for the single-port word memory model: accepts a block command (base address, word count, direction) and drives the memory's `wen`/`a`/`d` pins, one word per cycle, at 4-byte address stride. Write data arrives on a valid/ready input stream. Read data leaves on a valid/ready output stream. Sits between the core or testbench command source and the memory, replacing hand-driven memory pins in loaders and checkers.

---
 rtl/mem_burst_pkg.sv | 21 ++
 rtl/mem_rd_stage.sv | 46 ++++
 rtl/mem_burst_master.sv | 138 +++++++++++++
 tb/tb_mem_burst_master.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the memory burst master.
// The FSM state encoding and address helpers live here so the top and sub-modules agree.
package mem_burst_pkg;

    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] ADDR_STRIDE = 32'd4;
    localparam logic [ADDR_W-1:0] ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Word-align a byte address; the low two bits are never driven to memory.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mem_rd_stage.sv
// Single-entry read output register: loads on issue, holds under backpressure,
// and empties when the consumer takes the word without a replacement arriving.
module mem_rd_stage #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [BITS-1:0] load_data,
    input  logic            ready,
    output logic            valid,
    output logic [BITS-1:0] data
);

    logic            valid_q, valid_d;
    logic [BITS-1:0] data_q, data_d;

    // Next-state for the holding register.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {BITS{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/mem_burst_master.sv
// Block-transfer initiator for the single-port word memory: one word per cycle
// at 4-byte stride, write data from a valid/ready stream, read data to another.
module mem_burst_master
    import mem_burst_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [BITS-1:0]   wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [BITS-1:0]   rd_data,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_a,
    output logic [BITS-1:0]   mem_d,
    input  logic [BITS-1:0]   mem_q,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              rd_issue_s;

    // Next-state, counters and read issue decision.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_issue_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = align_addr(cmd_addr);
                    cnt_d  = cmd_len;
                    if (cmd_len == CNT_ZERO) begin
                        state_d = DONE;
                    end else if (cmd_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    addr_d = addr_q + ADDR_STRIDE;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            READ: begin
                // Issue only when the output slot is empty or draining this cycle.
                rd_issue_s = (cnt_q != CNT_ZERO) && (!rd_valid || rd_ready);
                if (rd_issue_s) begin
                    addr_d = addr_q + ADDR_STRIDE;
                    cnt_d  = cnt_q - CNT_ONE;
                end else begin
                    addr_d = addr_q;
                    cnt_d  = cnt_q;
                end
                if ((cnt_q == CNT_ZERO) && rd_valid && rd_ready) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, address and count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake and memory pins; gated by reset so nothing is accepted or written while held.
    always_comb begin
        cmd_ready = rst_n && (state_q == IDLE);
        wr_ready  = rst_n && (state_q == WRITE);
        mem_wen   = rst_n && (state_q == WRITE) && wr_valid;
        busy      = rst_n && (state_q != IDLE);
        done      = rst_n && (state_q == DONE);
        mem_a     = addr_q;
        if (state_q == WRITE) begin
            mem_d = wr_data;
        end else begin
            mem_d = {BITS{1'b0}};
        end
    end

    mem_rd_stage #(
        .BITS(BITS)
    ) u_rd_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (rd_issue_s),
        .load_data (mem_q),
        .ready     (rd_ready),
        .valid     (rd_valid),
        .data      (rd_data)
    );

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed cycle-vector bench for mem_burst_master with a small word memory model.
module tb_mem_burst_master;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        mem_wen;
    logic [31:0] mem_a, mem_d, mem_q;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_a[7:2]] <= mem_d;
    end
    assign mem_q = mem[mem_a[7:2]];

    mem_burst_master #(.BITS(32), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
        .busy(busy), .done(done)
    );

    // Inputs for one cycle followed by the outputs expected in that same cycle.
    typedef struct {
        logic        cv, cw;
        logic [31:0] ca;
        logic [7:0]  cl;
        logic        wv;
        logic [31:0] wd;
        logic        rr;
        logic        cr, wrr, bsy, dn, wen, chka;
        logic [31:0] a;
        logic        rv, crd;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [36];

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic run_vec(input int row);
        vec_t v;
        v = tbl[row];
        @(negedge clk);
        cmd_valid = v.cv; cmd_write = v.cw; cmd_addr = v.ca; cmd_len = v.cl;
        wr_valid = v.wv; wr_data = v.wd; rd_ready = v.rr;
        #1;
        chk("cmd_ready", row, {31'd0, cmd_ready}, {31'd0, v.cr});
        chk("wr_ready",  row, {31'd0, wr_ready},  {31'd0, v.wrr});
        chk("busy",      row, {31'd0, busy},      {31'd0, v.bsy});
        chk("done",      row, {31'd0, done},      {31'd0, v.dn});
        chk("mem_wen",   row, {31'd0, mem_wen},   {31'd0, v.wen});
        chk("rd_valid",  row, {31'd0, rd_valid},  {31'd0, v.rv});
        if (v.chka) chk("mem_a", row, mem_a, v.a);
        if (v.wen)  chk("mem_d", row, mem_d, v.wd);
        if (v.crd)  chk("rd_data", row, rd_data, v.rd);
    endtask

    initial begin
        // write 4 words at 0x1000
        tbl[0]  = '{H,H,32'h1000,8'd4,L,32'h0,L, H,L,L,L,L,H,32'h0,L,L,32'h0};
        tbl[1]  = '{L,L,32'h0,8'd0,H,32'hA0,L, L,H,H,L,H,H,32'h1000,L,L,32'h0};
        tbl[2]  = '{L,L,32'h0,8'd0,H,32'hA1,L, L,H,H,L,H,H,32'h1004,L,L,32'h0};
        tbl[3]  = '{L,L,32'h0,8'd0,H,32'hA2,L, L,H,H,L,H,H,32'h1008,L,L,32'h0};
        tbl[4]  = '{L,L,32'h0,8'd0,H,32'hA3,L, L,H,H,L,H,H,32'h100C,L,L,32'h0};
        tbl[5]  = '{L,L,32'h0,8'd0,L,32'h0,L, L,L,H,H,L,L,32'h0,L,L,32'h0};
        // read them back at full rate
        tbl[6]  = '{H,L,32'h1000,8'd4,L,32'h0,H, H,L,L,L,L,L,32'h0,L,L,32'h0};
        tbl[7]  = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,L,L,H,32'h1000,L,L,32'h0};
        tbl[8]  = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,L,L,H,32'h1004,H,H,32'hA0};
        tbl[9]  = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,L,L,H,32'h1008,H,H,32'hA1};
        tbl[10] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,L,L,H,32'h100C,H,H,32'hA2};
        tbl[11] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,L,L,L,32'h0,H,H,32'hA3};
        tbl[12] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,H,L,L,32'h0,L,L,32'h0};
        // zero-length read
        tbl[13] = '{H,L,32'h2000,8'd0,L,32'h0,H, H,L,L,L,L,L,32'h0,L,L,32'h0};
        tbl[14] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,H,L,L,32'h0,L,L,32'h0};
        tbl[15] = '{L,L,32'h0,8'd0,L,32'h0,H, H,L,L,L,L,L,32'h0,L,L,32'h0};
        // 3-word read with rd_ready 1,0,0,1,1 then 1
        tbl[16] = '{H,L,32'h1000,8'd3,L,32'h0,L, H,L,L,L,L,L,32'h0,L,L,32'h0};
        tbl[17] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,L,L,H,32'h1000,L,L,32'h0};
        tbl[18] = '{L,L,32'h0,8'd0,L,32'h0,L, L,L,H,L,L,H,32'h1004,H,H,32'hA0};
        tbl[19] = '{L,L,32'h0,8'd0,L,32'h0,L, L,L,H,L,L,H,32'h1004,H,H,32'hA0};
        tbl[20] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,L,L,H,32'h1004,H,H,32'hA0};
        tbl[21] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,L,L,H,32'h1008,H,H,32'hA1};
        tbl[22] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,L,L,L,32'h0,H,H,32'hA2};
        tbl[23] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,H,L,L,32'h0,L,L,32'h0};
        // 2-word write at unaligned 0xFFFF_FFFE with one bubble, wrapping to 0
        tbl[24] = '{H,H,32'hFFFF_FFFE,8'd2,L,32'h0,L, H,L,L,L,L,L,32'h0,L,L,32'h0};
        tbl[25] = '{L,L,32'h0,8'd0,L,32'h0,L, L,H,H,L,L,H,32'hFFFF_FFFC,L,L,32'h0};
        tbl[26] = '{L,L,32'h0,8'd0,H,32'hB0,L, L,H,H,L,H,H,32'hFFFF_FFFC,L,L,32'h0};
        tbl[27] = '{L,L,32'h0,8'd0,H,32'hB1,L, L,H,H,L,H,H,32'h0,L,L,32'h0};
        tbl[28] = '{L,L,32'h0,8'd0,L,32'h0,L, L,L,H,H,L,L,32'h0,L,L,32'h0};
        // 8-word write interrupted by reset after two beats
        tbl[29] = '{H,H,32'h3000,8'd8,L,32'h0,L, H,L,L,L,L,L,32'h0,L,L,32'h0};
        tbl[30] = '{L,L,32'h0,8'd0,H,32'hC0,L, L,H,H,L,H,H,32'h3000,L,L,32'h0};
        tbl[31] = '{L,L,32'h0,8'd0,H,32'hC1,L, L,H,H,L,H,H,32'h3004,L,L,32'h0};
        // after release: 1-word read of 0x3004
        tbl[32] = '{H,L,32'h3004,8'd1,L,32'h0,H, H,L,L,L,L,L,32'h0,L,L,32'h0};
        tbl[33] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,L,L,H,32'h3004,L,L,32'h0};
        tbl[34] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,L,L,L,32'h0,H,H,32'hC1};
        tbl[35] = '{L,L,32'h0,8'd0,L,32'h0,H, L,L,H,H,L,L,32'h0,L,L,32'h0};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 8'd0;
        wr_valid = 1'b0; wr_data = 32'h0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_cmd_ready", -1, {31'd0, cmd_ready}, 32'd0);
        chk("rst_wr_ready",  -1, {31'd0, wr_ready},  32'd0);
        chk("rst_rd_valid",  -1, {31'd0, rd_valid},  32'd0);
        chk("rst_rd_data",   -1, rd_data, 32'd0);
        chk("rst_mem_wen",   -1, {31'd0, mem_wen},   32'd0);
        chk("rst_mem_a",     -1, mem_a, 32'd0);
        chk("rst_mem_d",     -1, mem_d, 32'd0);
        chk("rst_busy",      -1, {31'd0, busy},      32'd0);
        chk("rst_done",      -1, {31'd0, done},      32'd0);
        rst_n = 1'b1;

        for (int i = 0; i <= 28; i++) run_vec(i);
        chk("mem_wrap_hi", -2, mem[63], 32'hB0);
        chk("mem_wrap_lo", -2, mem[0],  32'hB1);

        for (int i = 29; i <= 31; i++) run_vec(i);
        @(negedge clk);
        rst_n = 1'b0; wr_valid = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_busy",     -3, {31'd0, busy},     32'd0);
        chk("abort_wr_ready", -3, {31'd0, wr_ready}, 32'd0);
        chk("abort_done",     -3, {31'd0, done},     32'd0);
        chk("abort_mem_wen",  -3, {31'd0, mem_wen},  32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_cmd_ready", -3, {31'd0, cmd_ready}, 32'd1);
        chk("release_done",      -3, {31'd0, done},      32'd0);
        chk("mem_beat0", -3, mem[0], 32'hC0);
        chk("mem_beat1", -3, mem[1], 32'hC1);
        chk("mem_untouched", -3, mem[2], 32'hA2);

        for (int i = 32; i <= 35; i++) run_vec(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
